// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 INTA sequencer slice.
package pic_pkg;

  localparam int unsigned NUM_IRQ      = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned SPURIOUS_IDX = 7;
  localparam int unsigned VEC_BASE_W   = 5;
  localparam int unsigned DATA_W       = 8;

  // EOI command flavour carried on eoi_specific
  localparam logic EOI_NONSPECIFIC = 1'b0;
  localparam logic EOI_SPECIFIC    = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } state_e;

  // Lowest set bit index (IR0 is highest priority); 0 when the vector is empty
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Fixed-priority resolver: finds the highest-priority request that outranks ISR.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_req,
  input  logic [NUM_IRQ-1:0] i_isr,
  output logic               o_found_c,
  output logic [IDX_W-1:0]   o_idx_c
);

  logic [IDX_W-1:0] w_isr_idx;

  // A request wins only if strictly higher priority than the top in-service bit
  always_comb begin
    o_idx_c   = lowest_idx(i_req);
    w_isr_idx = lowest_idx(i_isr);
    o_found_c = (|i_req) && (~|i_isr || (o_idx_c < w_isr_idx));
  end

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side INT/INTA responder of the 8259: two-pulse handshake, vector drive, ISR/EOI.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_IRQ-1:0]    i_irq_status,
  input  logic [NUM_IRQ-1:0]    i_imr,
  input  logic [VEC_BASE_W-1:0] i_vector_base,
  input  logic                  i_aeoi,
  input  logic                  i_inta_n,
  input  logic                  i_eoi_req,
  input  logic                  i_eoi_specific,
  input  logic [IDX_W-1:0]      i_eoi_level,
  output logic                  o_int_out,
  output logic                  o_ack_valid,
  output logic [IDX_W-1:0]      o_ack_idx,
  output logic [NUM_IRQ-1:0]    o_isr,
  output logic [DATA_W-1:0]     o_data_out,
  output logic                  o_data_oe
);

  state_e              r_state;
  logic                r_inta_n_d;
  logic [IDX_W-1:0]    r_idx;
  logic                r_spurious;
  logic                r_int_out;
  logic                r_ack_valid;
  logic [IDX_W-1:0]    r_ack_idx;
  logic [NUM_IRQ-1:0]  r_isr;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_oe;

  state_e              w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_spurious_nxt;
  logic                w_int_nxt;
  logic                w_ack_valid_nxt;
  logic [IDX_W-1:0]    w_ack_idx_nxt;
  logic [NUM_IRQ-1:0]  w_isr_nxt;
  logic [DATA_W-1:0]   w_data_out_nxt;
  logic                w_data_oe_nxt;
  logic [NUM_IRQ-1:0]  w_isr_set;
  logic [NUM_IRQ-1:0]  w_aeoi_clr;
  logic [NUM_IRQ-1:0]  w_eoi_clr;

  logic [NUM_IRQ-1:0]  w_req;
  logic                w_cand_found;
  logic [IDX_W-1:0]    w_cand_idx;
  logic                w_isr_found;
  logic [IDX_W-1:0]    w_isr_idx;
  logic                w_fall;
  logic                w_rise;

  assign w_req  = i_irq_status & ~i_imr;
  assign w_fall = r_inta_n_d & ~i_inta_n;
  assign w_rise = ~r_inta_n_d & i_inta_n;

  priority_resolver u_cand (
    .i_req     (w_req),
    .i_isr     (r_isr),
    .o_found_c (w_cand_found),
    .o_idx_c   (w_cand_idx)
  );

  // Top in-service bit, target of a non-specific EOI
  priority_resolver u_isr_top (
    .i_req     (r_isr),
    .i_isr     ({NUM_IRQ{1'b0}}),
    .o_found_c (w_isr_found),
    .o_idx_c   (w_isr_idx)
  );

  // EOI clear mask, computed against the current (pre-set) ISR
  always_comb begin
    w_eoi_clr = '0;
    if (i_eoi_req) begin
      case (i_eoi_specific)
        EOI_SPECIFIC:    w_eoi_clr[i_eoi_level] = 1'b1;
        EOI_NONSPECIFIC: if (w_isr_found) w_eoi_clr[w_isr_idx] = 1'b1;
      endcase
    end
  end

  // Handshake next-state and registered-output next values
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_spurious_nxt  = r_spurious;
    w_ack_valid_nxt = 1'b0;
    w_ack_idx_nxt   = r_ack_idx;
    w_isr_set       = '0;
    w_aeoi_clr      = '0;
    w_data_out_nxt  = r_data_out;
    w_data_oe_nxt   = r_data_oe;

    case (r_state)
      IDLE: begin
        if (w_cand_found) w_state_nxt = PEND;
      end
      PEND: begin
        // INT stays up even if the request vanishes; pulse 1 then goes spurious
        if (w_fall) begin
          w_state_nxt = ACK1;
          if (w_cand_found) begin
            w_idx_nxt              = w_cand_idx;
            w_spurious_nxt         = 1'b0;
            w_ack_valid_nxt        = 1'b1;
            w_ack_idx_nxt          = w_cand_idx;
            w_isr_set[w_cand_idx]  = 1'b1;
          end else begin
            w_idx_nxt      = IDX_W'(SPURIOUS_IDX);
            w_spurious_nxt = 1'b1;
          end
        end
      end
      ACK1: begin
        if (w_rise) w_state_nxt = GAP;
      end
      GAP: begin
        if (w_fall) begin
          w_state_nxt    = ACK2;
          w_data_oe_nxt  = 1'b1;
          w_data_out_nxt = {i_vector_base, r_idx};
        end
      end
      ACK2: begin
        if (w_rise) begin
          w_state_nxt    = IDLE;
          w_data_oe_nxt  = 1'b0;
          w_data_out_nxt = '0;
          if (i_aeoi && !r_spurious) w_aeoi_clr[r_idx] = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_int_nxt = (w_state_nxt == PEND);
    // A set on the same bit as an EOI clear wins
    w_isr_nxt = ((r_isr & ~w_eoi_clr) | w_isr_set) & ~w_aeoi_clr;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_inta_n_d  <= 1'b1;
      r_idx       <= '0;
      r_spurious  <= 1'b0;
      r_int_out   <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_idx   <= '0;
      r_isr       <= '0;
      r_data_out  <= '0;
      r_data_oe   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_inta_n_d  <= i_inta_n;
      r_idx       <= w_idx_nxt;
      r_spurious  <= w_spurious_nxt;
      r_int_out   <= w_int_nxt;
      r_ack_valid <= w_ack_valid_nxt;
      r_ack_idx   <= w_ack_idx_nxt;
      r_isr       <= w_isr_nxt;
      r_data_out  <= w_data_out_nxt;
      r_data_oe   <= w_data_oe_nxt;
    end
  end

  assign o_int_out   = r_int_out;
  assign o_ack_valid = r_ack_valid;
  assign o_ack_idx   = r_ack_idx;
  assign o_isr       = r_isr;
  assign o_data_out  = r_data_out;
  assign o_data_oe   = r_data_oe;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: per-cycle vector table plus handshake sequences.
module tb_inta_sequencer;

  logic       i_clk;
  logic       i_reset;
  logic [7:0] i_irq_status;
  logic [7:0] i_imr;
  logic [4:0] i_vector_base;
  logic       i_aeoi;
  logic       i_inta_n;
  logic       i_eoi_req;
  logic       i_eoi_specific;
  logic [2:0] i_eoi_level;
  logic       o_int_out;
  logic       o_ack_valid;
  logic [2:0] o_ack_idx;
  logic [7:0] o_isr;
  logic [7:0] o_data_out;
  logic       o_data_oe;

  int errors = 0;
  int checks = 0;

  inta_sequencer dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_irq_status   (i_irq_status),
    .i_imr          (i_imr),
    .i_vector_base  (i_vector_base),
    .i_aeoi         (i_aeoi),
    .i_inta_n       (i_inta_n),
    .i_eoi_req      (i_eoi_req),
    .i_eoi_specific (i_eoi_specific),
    .i_eoi_level    (i_eoi_level),
    .o_int_out      (o_int_out),
    .o_ack_valid    (o_ack_valid),
    .o_ack_idx      (o_ack_idx),
    .o_isr          (o_isr),
    .o_data_out     (o_data_out),
    .o_data_oe      (o_data_oe)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] irq;
    logic       inta_n;
    logic       eoi_req;
    logic       eoi_spec;
    logic [2:0] eoi_lvl;
    logic       e_int;
    logic       e_ack;
    logic [2:0] e_idx;
    logic [7:0] e_isr;
    logic [7:0] e_dout;
    logic       e_oe;
  } vec_t;

  vec_t vecs [10];

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    i_reset = 1'b1;
    cyc();
    cyc();
    i_reset = 1'b0;
    chk({tag, "_int"},  32'(o_int_out),   32'd0);
    chk({tag, "_ack"},  32'(o_ack_valid), 32'd0);
    chk({tag, "_idx"},  32'(o_ack_idx),   32'd0);
    chk({tag, "_isr"},  32'(o_isr),       32'd0);
    chk({tag, "_dout"}, 32'(o_data_out),  32'd0);
    chk({tag, "_oe"},   32'(o_data_oe),   32'd0);
  endtask

  // Full two-pulse INTA starting from PEND; any EOI set up by the caller rides the fall cycle
  task automatic do_ack(input string tag, input logic exp_valid, input logic [2:0] exp_idx,
                        input logic [7:0] exp_isr, input logic [7:0] exp_vec,
                        input logic [7:0] irq_after, input logic [7:0] exp_isr_end);
    i_inta_n = 1'b0;
    cyc();
    i_eoi_req = 1'b0;
    chk({tag, "_p1_ack"}, 32'(o_ack_valid), 32'(exp_valid));
    if (exp_valid) chk({tag, "_p1_idx"}, 32'(o_ack_idx), 32'(exp_idx));
    chk({tag, "_p1_isr"}, 32'(o_isr), 32'(exp_isr));
    chk({tag, "_p1_int"}, 32'(o_int_out), 32'd0);
    i_irq_status = irq_after;
    i_inta_n = 1'b1;
    cyc();
    chk({tag, "_gap_ack"}, 32'(o_ack_valid), 32'd0);
    i_inta_n = 1'b0;
    cyc();
    chk({tag, "_p2_oe"},   32'(o_data_oe),  32'd1);
    chk({tag, "_p2_dout"}, 32'(o_data_out), 32'(exp_vec));
    cyc();
    chk({tag, "_p2_oe2"},  32'(o_data_oe),  32'd1);
    i_inta_n = 1'b1;
    cyc();
    chk({tag, "_end_oe"},   32'(o_data_oe),  32'd0);
    chk({tag, "_end_dout"}, 32'(o_data_out), 32'd0);
    chk({tag, "_end_isr"},  32'(o_isr),      32'(exp_isr_end));
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    i_eoi_req      = 1'b1;
    i_eoi_specific = spec;
    i_eoi_level    = lvl;
    cyc();
    i_eoi_req      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset        = 1'b1;
    i_irq_status   = 8'h00;
    i_imr          = 8'h00;
    i_vector_base  = 5'h10;
    i_aeoi         = 1'b0;
    i_inta_n       = 1'b1;
    i_eoi_req      = 1'b0;
    i_eoi_specific = 1'b0;
    i_eoi_level    = 3'd0;

    // Basic sequence on IR3, one row per clock: inputs, then expected outputs after the edge
    //             irq    inta  eoi   spec  lvl   int   ack   idx   isr    dout   oe
    vecs[0] = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h08, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h08, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h08, 8'h00, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h08, 8'h83, 1'b1};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h08, 8'h83, 1'b1};
    vecs[8] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h08, 8'h00, 1'b0};
    vecs[9] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0};

    do_reset("rst0");

    for (int i = 0; i < 10; i++) begin
      i_irq_status   = vecs[i].irq;
      i_inta_n       = vecs[i].inta_n;
      i_eoi_req      = vecs[i].eoi_req;
      i_eoi_specific = vecs[i].eoi_spec;
      i_eoi_level    = vecs[i].eoi_lvl;
      cyc();
      chk($sformatf("v%0d_int", i),  32'(o_int_out),   32'(vecs[i].e_int));
      chk($sformatf("v%0d_ack", i),  32'(o_ack_valid), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_idx", i),  32'(o_ack_idx),   32'(vecs[i].e_idx));
      chk($sformatf("v%0d_isr", i),  32'(o_isr),       32'(vecs[i].e_isr));
      chk($sformatf("v%0d_dout", i), 32'(o_data_out),  32'(vecs[i].e_dout));
      chk($sformatf("v%0d_oe", i),   32'(o_data_oe),   32'(vecs[i].e_oe));
    end
    i_eoi_req = 1'b0;

    // Priority: IR2 beats IR5; IR5 waits until a non-specific EOI retires IR2
    i_irq_status = 8'h24;
    cyc();
    chk("prio_int", 32'(o_int_out), 32'd1);
    do_ack("prio2", 1'b1, 3'd2, 8'h04, 8'h82, 8'h20, 8'h04);
    cyc();
    chk("prio_blocked_int", 32'(o_int_out), 32'd0);
    eoi(1'b0, 3'd0);
    chk("prio_eoi_isr", 32'(o_isr), 32'h00);
    cyc();
    chk("prio5_int", 32'(o_int_out), 32'd1);
    do_ack("prio5", 1'b1, 3'd5, 8'h20, 8'h85, 8'h00, 8'h20);
    eoi(1'b0, 3'd0);
    chk("prio5_eoi_isr", 32'(o_isr), 32'h00);

    // Nesting: IR6 cannot interrupt IR4, IR1 can
    do_reset("rst1");
    i_irq_status = 8'h10;
    cyc();
    chk("nest4_int", 32'(o_int_out), 32'd1);
    do_ack("nest4", 1'b1, 3'd4, 8'h10, 8'h84, 8'h00, 8'h10);
    i_irq_status = 8'h40;
    cyc();
    cyc();
    chk("nest6_no_int", 32'(o_int_out), 32'd0);
    i_irq_status = 8'h42;
    cyc();
    chk("nest1_int", 32'(o_int_out), 32'd1);
    do_ack("nest1", 1'b1, 3'd1, 8'h12, 8'h81, 8'h40, 8'h12);
    i_irq_status = 8'h00;
    eoi(1'b1, 3'd4);
    chk("nest_spec_eoi", 32'(o_isr), 32'h02);
    eoi(1'b0, 3'd0);
    chk("nest_nonspec_eoi", 32'(o_isr), 32'h00);

    // Spurious: request withdrawn and masked while INT is already up
    i_irq_status = 8'h08;
    cyc();
    chk("spur_int", 32'(o_int_out), 32'd1);
    i_irq_status = 8'h00;
    i_imr        = 8'h08;
    cyc();
    chk("spur_int_held", 32'(o_int_out), 32'd1);
    do_ack("spur", 1'b0, 3'd7, 8'h00, 8'h87, 8'h00, 8'h00);
    i_imr = 8'h00;
    cyc();
    chk("spur_idle_int", 32'(o_int_out), 32'd0);

    // AEOI: IR0 retires itself on the rise of pulse 2; a specific EOI on an empty ISR is a no-op
    i_aeoi       = 1'b1;
    i_irq_status = 8'h01;
    cyc();
    do_ack("aeoi0", 1'b1, 3'd0, 8'h01, 8'h80, 8'h00, 8'h00);
    eoi(1'b1, 3'd4);
    chk("aeoi_noop_eoi", 32'(o_isr), 32'h00);
    i_aeoi = 1'b0;

    // Set and specific EOI on the same bit in the same cycle: set wins
    i_irq_status = 8'h08;
    cyc();
    i_eoi_req      = 1'b1;
    i_eoi_specific = 1'b1;
    i_eoi_level    = 3'd3;
    do_ack("same", 1'b1, 3'd3, 8'h08, 8'h83, 8'h00, 8'h08);
    eoi(1'b0, 3'd0);
    chk("same_clear", 32'(o_isr), 32'h00);

    // Reset during GAP, then a clean IR2 sequence
    i_irq_status = 8'h04;
    cyc();
    i_inta_n = 1'b0;
    cyc();
    chk("rg_p1_isr", 32'(o_isr), 32'h04);
    i_irq_status = 8'h00;
    i_inta_n = 1'b1;
    cyc();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    chk("rg_isr", 32'(o_isr),       32'h00);
    chk("rg_oe",  32'(o_data_oe),   32'd0);
    chk("rg_int", 32'(o_int_out),   32'd0);
    chk("rg_ack", 32'(o_ack_valid), 32'd0);
    i_irq_status = 8'h04;
    cyc();
    chk("rg2_int", 32'(o_int_out), 32'd1);
    do_ack("rg2", 1'b1, 3'd2, 8'h04, 8'h82, 8'h00, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
